flot_isqrt_arbiter: RTL and testbench

//  Shares one fixed-latency pipelined float inverse-sqrt unit among N_REQ requesters.

---
 rtl/flot_isqrt_arbiter_pkg.sv | 42 ++++
 rtl/flot_isqrt_arbiter_if.sv | 32 +++
 rtl/flot_isqrt_arbiter_rr_grant_sel.sv | 56 +++++
 rtl/flot_isqrt_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_flot_isqrt_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/flot_isqrt_arbiter_pkg.sv
// Shared definitions for the float inverse-sqrt arbiter slice.
// Holds the FSM state encoding, the in-flight tag type, the default
// configuration and a constant log2 helper used to size IDs and counters.
// No ports (package).
package flot_isqrt_arb_pkg;

    // Returns ceil(log2(n)), but never less than 1, so that the result can
    // size a vector even when n is 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int WIDTH_DEF = 32;
    localparam int N_REQ_DEF = 4;
    localparam int LAT_DEF   = 4;

    // Requester ID width. Tags are built from this width, so a build with
    // more requesters than 2**ID_W needs N_REQ_DEF raised here.
    localparam int ID_W = clog2(N_REQ_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One entry of the tag shift register: which requester owns the op
    // travelling alongside it through the unit.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/flot_isqrt_arbiter_if.sv
// Requester-side bus of the float inverse-sqrt arbiter.
// Signals:
//   req_valid  [N_REQ]        operand valid per requester
//   req_op     [N_REQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   req_exce   [N_REQ]        exception-in flag per requester
//   req_ready  [N_REQ]        one-hot grant back to the requesters
//   rsp_valid  [N_REQ]        one-hot result strobe
//   rsp_result [WIDTH]        shared result word
//   rsp_exce                  exception flag travelling with the result
// Modports: master (requesters), slave (arbiter).
interface flot_isqrt_arbiter_if #(
    parameter int WIDTH = flot_isqrt_arb_pkg::WIDTH_DEF,
    parameter int N_REQ = flot_isqrt_arb_pkg::N_REQ_DEF
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_op;
    logic [N_REQ-1:0]       req_exce;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]       rsp_result;
    logic                   rsp_exce;

    modport master (
        output req_valid, req_op, req_exce,
        input  req_ready, rsp_valid, rsp_result, rsp_exce
    );

    modport slave (
        input  req_valid, req_op, req_exce,
        output req_ready, rsp_valid, rsp_result, rsp_exce
    );
endinterface

// File: rtl/flot_isqrt_arbiter_rr_grant_sel.sv
// Grant selector for the float inverse-sqrt arbiter.
// Picks one requester out of a valid vector and reports it both one-hot and
// as an index. Default build: round-robin search starting at ptr.
// Build option ISQRT_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins,
// ptr is ignored.
// Ports:
//   req    in  [N_REQ]  requester valid vector
//   ptr    in  [ID_W]   round-robin start position
//   grant  out [N_REQ]  one-hot selected requester (0 when none)
//   idx    out [ID_W]   index of selected requester
//   any    out          a requester was selected
module rr_grant_sel #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    int start;

`ifdef ISQRT_ARB_FIXED_PRIO_EN
    // With fixed priority the search always begins at requester 0; the
    // pointer is kept on the port so both builds share one interface.
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign start = 0;
`else
    assign start = int'(ptr);
`endif

    // Walk the requesters from the start position, wrapping at N_REQ, and
    // take the first one that is valid.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_idx;
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (start + k) % N_REQ;
            cand_idx = ID_W'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                idx             = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/flot_isqrt_arbiter.sv
// Shares one fixed-latency pipelined float inverse-sqrt unit among N_REQ
// requesters. At most one operand is issued per cycle; a tag shift register
// that advances with the unit's clock enable remembers who owns each
// in-flight op so the result can be routed back. A flush request stops
// granting, lets the pipe empty and then pulses flush_done.
// Build option ISQRT_ARB_FIXED_PRIO_EN selects fixed priority instead of
// round-robin granting.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   bus            requester bus (slave side)
//   flush_req      in   stop granting and drain the pipe
//   flush_done     out  one-cycle pulse once the drain completes
//   busy           out  ops in flight or not idle
//   pipe_ce        out  unit clock enable
//   pipe_op        out  operand to the unit
//   pipe_exce_in   out  exception-in to the unit
//   pipe_result    in   unit result
//   pipe_exce_out  in   unit exception-out
module flot_isqrt_arbiter
    import flot_isqrt_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = N_REQ_DEF,
    parameter int LAT   = LAT_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    flot_isqrt_arbiter_if.slave  bus,
    input  logic                 flush_req,
    output logic                 flush_done,
    output logic                 busy,
    output logic                 pipe_ce,
    output logic [WIDTH-1:0]     pipe_op,
    output logic                 pipe_exce_in,
    input  logic [WIDTH-1:0]     pipe_result,
    input  logic                 pipe_exce_out
);

    localparam int CNT_W = clog2(LAT + 1);

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  ptr;
    tag_t             tag_pipe [LAT];
    logic [CNT_W-1:0] count;

    logic [N_REQ-1:0] sel_grant;
    logic [ID_W-1:0]  sel_idx;
    logic             sel_any;
    logic             grant_en;
    logic             grant;
    logic             retire;

    logic [N_REQ-1:0] rsp_valid_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_exce_q;
    logic             flush_done_q;

    rr_grant_sel #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_grant_sel (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (sel_grant),
        .idx   (sel_idx),
        .any   (sel_any)
    );

    // Granting is only allowed outside DRAIN and when no flush is being
    // requested this cycle; a flush always beats a pending grant. Reset also
    // blocks it so the combinational outputs are quiet while RST is high.
    // The unit runs whenever something enters or something is in flight,
    // which keeps the tag register aligned with the unit's stages.
    always_comb begin
        grant_en      = !RST && !flush_req && (state != DRAIN);
        grant         = grant_en && sel_any;
        bus.req_ready = grant_en ? sel_grant : '0;
        pipe_ce       = !RST && (grant || (count != '0));
        retire        = pipe_ce && tag_pipe[LAT-1].valid;
        busy          = (count != '0) || (state != IDLE);
    end

    // Steer the granted requester's operand onto the unit input with an
    // AND-OR mux over the one-hot grant; the input is zero when idle.
    always_comb begin
        pipe_op      = '0;
        pipe_exce_in = 1'b0;
        if (grant) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (sel_grant[i]) begin
                    pipe_op      = bus.req_op[i*WIDTH +: WIDTH];
                    pipe_exce_in = bus.req_exce[i];
                end
            end
        end
    end

    // Next-state logic. A flush from IDLE or RUN moves to DRAIN; further
    // flush requests are ignored until the pipe is empty again.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = DRAIN;
                end else if (|bus.req_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush_req) begin
                    state_next = DRAIN;
                end else if (!(|bus.req_valid) && (count == '0)) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus the flush_done pulse, which fires on the cycle
    // after DRAIN sees an empty pipe, i.e. one cycle after the last result.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            flush_done_q <= (state == DRAIN) && (count == '0);
        end
    end

    // Round-robin pointer: moves just past the requester that was served so
    // it gets lowest priority next time. Held at zero for fixed priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr <= '0;
        end else begin
`ifdef ISQRT_ARB_FIXED_PRIO_EN
            ptr <= '0;
`else
            if (grant) begin
                ptr <= (sel_idx == ID_W'(N_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
            end
`endif
        end
    end

    // Tag shift register. It advances only with the unit's clock enable so
    // that stage LAT-1 always describes the result currently at the unit
    // output. Reset invalidates every tag, dropping any in-flight ops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else if (pipe_ce) begin
            tag_pipe[0].valid <= grant;
            tag_pipe[0].id    <= sel_idx;
            for (int i = 1; i < LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // In-flight counter. An issue and a retire in the same cycle cancel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else begin
            case ({grant, retire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response register. The result word and exception flag are captured
    // when an owned op leaves the unit and hold otherwise; the one-hot
    // strobe lasts a single cycle since responses cannot be stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_exce_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            if (retire) begin
                rsp_valid_q[tag_pipe[LAT-1].id] <= 1'b1;
                rsp_result_q                    <= pipe_result;
                rsp_exce_q                      <= pipe_exce_out;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_exce   = rsp_exce_q;
    assign flush_done     = flush_done_q;

endmodule

// File: tb/tb_flot_isqrt_arbiter.sv
// Self-checking bench for flot_isqrt_arbiter. A behavioural unit stub
// (result = op + 1 after LAT enabled cycles, exception passed through) sits
// on the pipe side; a queue-based reference model predicts grants, unit
// inputs, responses, flush_done and busy every cycle.
module tb_flot_isqrt_arbiter;

    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int LAT   = 4;

`ifdef ISQRT_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             flush_req = 1'b0;
    logic             flush_done;
    logic             busy;
    logic             pipe_ce;
    logic [WIDTH-1:0] pipe_op;
    logic             pipe_exce_in;
    logic [WIDTH-1:0] pipe_result;
    logic             pipe_exce_out;

    int errors = 0;
    int checks = 0;

    flot_isqrt_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    flot_isqrt_arbiter #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .LAT   (LAT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .bus           (bus),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .busy          (busy),
        .pipe_ce       (pipe_ce),
        .pipe_op       (pipe_op),
        .pipe_exce_in  (pipe_exce_in),
        .pipe_result   (pipe_result),
        .pipe_exce_out (pipe_exce_out)
    );

    always #5 CLK = ~CLK;

    // Behavioural unit stub: an LAT-deep pipeline advancing on pipe_ce.
    logic [WIDTH-1:0] stub_res [LAT];
    logic             stub_exc [LAT];

    always @(posedge CLK) begin
        if (pipe_ce) begin
            stub_res[0] <= pipe_op + 32'd1;
            stub_exc[0] <= pipe_exce_in;
            for (int i = 1; i < LAT; i++) begin
                stub_res[i] <= stub_res[i-1];
                stub_exc[i] <= stub_exc[i-1];
            end
        end
    end

    assign pipe_result   = stub_res[LAT-1];
    assign pipe_exce_out = stub_exc[LAT-1];

    // Reference model state: ops in flight with the number of enabled
    // edges they have already seen, plus the expected registered outputs.
    typedef struct {
        int          id;
        logic [31:0] res;
        logic        exce;
        int          age;
    } inflight_t;

    inflight_t   m_q[$];
    int          m_ptr;
    bit          m_draining;
    bit          m_active;
    logic [3:0]  e_rsp_valid;
    logic [31:0] e_rsp_result;
    logic        e_rsp_exce;
    logic        e_flush_done;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_ptr        = 0;
        m_draining   = 1'b0;
        m_active     = 1'b0;
        e_rsp_valid  = '0;
        e_rsp_result = '0;
        e_rsp_exce   = 1'b0;
        e_flush_done = 1'b0;
    endtask

    function automatic logic [N_REQ*WIDTH-1:0] randOps();
        logic [N_REQ*WIDTH-1:0] v;
        for (int i = 0; i < N_REQ; i++) begin
            v[i*WIDTH +: WIDTH] = $urandom;
        end
        return v;
    endfunction

    // Compare every output against the model, then advance the model by
    // what the coming clock edge should do.
    task automatic evalCycle(input logic [3:0] v, input logic [N_REQ*WIDTH-1:0] ops,
                             input logic [3:0] exce, input logic fl);
        int          g;
        int          base;
        int          c;
        bit          ce;
        bit          q_empty;
        logic [31:0] gop;
        g    = -1;
        base = FIXED_PRIO ? 0 : m_ptr;
        if (!m_draining && !fl) begin
            for (int k = 0; k < N_REQ; k++) begin
                c = (base + k) % N_REQ;
                if (g < 0 && v[c]) g = c;
            end
        end
        gop = (g >= 0) ? ops[g*WIDTH +: WIDTH] : 32'd0;
        ce  = (g >= 0) || (m_q.size() != 0);

        checkOutput("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        checkOutput("pipe_op", pipe_op, gop);
        checkOutput("pipe_exce_in", 32'(pipe_exce_in), (g >= 0) ? 32'(exce[g]) : 32'd0);
        checkOutput("pipe_ce", 32'(pipe_ce), 32'(ce));
        checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp_valid));
        checkOutput("rsp_result", bus.rsp_result, e_rsp_result);
        checkOutput("rsp_exce", 32'(bus.rsp_exce), 32'(e_rsp_exce));
        checkOutput("flush_done", 32'(flush_done), 32'(e_flush_done));
        checkOutput("busy", 32'(busy), 32'(m_q.size() != 0 || m_draining || m_active));

        q_empty     = (m_q.size() == 0);
        e_rsp_valid = '0;
        if (ce) begin
            if (!q_empty && m_q[0].age == LAT - 1) begin
                e_rsp_valid  = 4'(32'd1 << m_q[0].id);
                e_rsp_result = m_q[0].res;
                e_rsp_exce   = m_q[0].exce;
                void'(m_q.pop_front());
            end
            foreach (m_q[i]) m_q[i].age++;
            if (g >= 0) begin
                m_q.push_back('{id: g, res: gop + 32'd1, exce: exce[g], age: 0});
                m_ptr = (g + 1) % N_REQ;
            end
        end
        e_flush_done = m_draining && q_empty;
        if (m_draining) begin
            if (q_empty) m_draining = 1'b0;
        end else if (fl) begin
            m_draining = 1'b1;
            m_active   = 1'b0;
        end else if (m_active) begin
            if (v == 4'd0 && q_empty) m_active = 1'b0;
        end else if (v != 4'd0) begin
            m_active = 1'b1;
        end
    endtask

    // Drive one cycle of requester inputs just after a rising edge, check at
    // the falling edge and return just after the next rising edge.
    task automatic applyStimulus(input logic [3:0] v, input logic [N_REQ*WIDTH-1:0] ops,
                                 input logic [3:0] exce, input logic fl);
        bus.req_valid = v;
        bus.req_op    = ops;
        bus.req_exce  = exce;
        flush_req     = fl;
        @(negedge CLK);
        evalCycle(v, ops, exce, fl);
        @(posedge CLK);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'd0, randOps(), 4'd0, 1'b0);
    endtask

    task automatic doReset();
        RST           = 1'b1;
        bus.req_valid = '0;
        bus.req_exce  = '0;
        bus.req_op    = '0;
        flush_req     = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        modelReset();
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset rsp_result", bus.rsp_result, 32'd0);
        checkOutput("reset rsp_exce", 32'(bus.rsp_exce), 32'd0);
        checkOutput("reset flush_done", 32'(flush_done), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset pipe_ce", 32'(pipe_ce), 32'd0);
        checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        logic [N_REQ*WIDTH-1:0] ops;
        logic [3:0]             v;

        doReset();

        // Single operand from requester 0: result op+1 at t+LAT+1.
        ops = randOps();
        ops[31:0] = 32'h3F80_0000;
        applyStimulus(4'b0001, ops, 4'd0, 1'b0);
        idleCycles(LAT);
        checkOutput("single rsp_valid", 32'(bus.rsp_valid), 32'h1);
        checkOutput("single rsp_result", bus.rsp_result, 32'h3F80_0001);
        idleCycles(2);
        checkOutput("single busy after", 32'(busy), 32'd0);

        // Everybody requesting every cycle: rotating grants, back-to-back responses.
        for (int i = 0; i < 12; i++) applyStimulus(4'b1111, randOps(), 4'($urandom), 1'b0);
        idleCycles(LAT + 2);

        // Requester 2 held while requester 0 toggles.
        for (int i = 0; i < 10; i++) applyStimulus({1'b0, 1'b1, 1'b0, 1'(i % 2 == 0)}, randOps(), 4'd0, 1'b0);
        idleCycles(LAT + 2);

        // Three ops in flight, then flush with everyone still requesting.
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, randOps(), 4'($urandom), 1'b0);
        applyStimulus(4'b1111, randOps(), 4'd0, 1'b1);
        applyStimulus(4'b1111, randOps(), 4'd0, 1'b1);
        for (int i = 0; i < LAT + 3; i++) applyStimulus(4'b1111, randOps(), 4'd0, 1'b0);
        idleCycles(LAT + 2);

        // Single op with an idle gap, requester 1 raising an exception.
        applyStimulus(4'b0010, randOps(), 4'b0010, 1'b0);
        idleCycles(LAT);
        checkOutput("exce rsp_valid", 32'(bus.rsp_valid), 32'h2);
        checkOutput("exce rsp_exce", 32'(bus.rsp_exce), 32'h1);
        idleCycles(2);
        checkOutput("gap pipe_ce", 32'(pipe_ce), 32'd0);

        // Reset with two ops in flight: nothing stale may come out later.
        applyStimulus(4'b0101, randOps(), 4'd0, 1'b0);
        applyStimulus(4'b0101, randOps(), 4'd0, 1'b0);
        doReset();
        idleCycles(LAT + 3);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            v = 4'($urandom);
            if ($urandom_range(0, 3) == 0) v = 4'd0;
            applyStimulus(v, randOps(), 4'($urandom), ($urandom_range(0, 29) == 0));
        end
        idleCycles(LAT + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
